// File: rtl/clock_step_controller.sv
// Core clock-enable scheduler: halt, free-run at a divisor, single-step
// and N-pulse burst. Ports: CLK/RESET, halt_req, cmd_* handshake,
// core_ce pulse, state, burst_left and the ce_count pulse counter.
module clock_step_controller #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2,
  parameter int CE_CNT_W    = 32
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                halt_req,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [CNT_W-1:0]    cmd_arg,
  output logic                core_ce,
  output logic [1:0]          state,
  output logic [CNT_W-1:0]    burst_left,
  output logic [CE_CNT_W-1:0] ce_count
);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_BURST = 2'b11
  } st_e;

  st_e              st, st_n;
  logic [CNT_W-1:0] ph, ph_n;
  logic [CNT_W-1:0] div, div_n;
  logic [CNT_W-1:0] bl, bl_n;
  logic             ce_n;
  logic             accept;
  logic             due;

  assign cmd_ready  = !halt_req && (st == S_HALT || st == S_RUN);
  assign accept     = cmd_valid && cmd_ready;
  assign state      = st;
  assign burst_left = bl;

  // div is never 0, so div-1 cannot underflow.
  assign due = (ph == div - CNT_W'(1));

  always_comb begin
    st_n  = st;
    ph_n  = ph;
    div_n = div;
    bl_n  = bl;
    ce_n  = 1'b0;
    if (halt_req) begin
      st_n = S_HALT;
      ph_n = '0;
      bl_n = '0;
    end else if (accept) begin
      // A new command restarts the phase and swallows any due pulse.
      ph_n = '0;
      unique case (st_e'(cmd_op))
        S_HALT: st_n = S_HALT;
        S_RUN: begin
          div_n = (cmd_arg == '0) ? CNT_W'(1) : cmd_arg;
          st_n  = S_RUN;
        end
        S_STEP: st_n = S_STEP;
        S_BURST: begin
          bl_n = cmd_arg;
          st_n = (cmd_arg == '0) ? S_HALT : S_BURST;
        end
      endcase
    end else begin
      unique case (st)
        S_HALT: ;
        S_RUN: begin
          ce_n = due;
          ph_n = due ? '0 : ph + CNT_W'(1);
        end
        S_STEP: begin
          ce_n = 1'b1;
          st_n = S_HALT;
        end
        S_BURST: begin
          ce_n = due;
          ph_n = due ? '0 : ph + CNT_W'(1);
          if (due) begin
            bl_n = bl - CNT_W'(1);
            if (bl == CNT_W'(1)) st_n = S_HALT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      st       <= S_HALT;
      ph       <= '0;
      div      <= CNT_W'(DEFAULT_DIV);
      bl       <= '0;
      core_ce  <= 1'b0;
      ce_count <= '0;
    end else begin
      st      <= st_n;
      ph      <= ph_n;
      div     <= div_n;
      bl      <= bl_n;
      core_ce <= ce_n;
      if (ce_n) ce_count <= ce_count + CE_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_clock_step_controller.sv
// Directed scoreboard bench for clock_step_controller.
// Expected per-edge outputs are queued per command and popped each cycle.
module tb_clock_step_controller;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        halt_req;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic        core_ce;
  logic [1:0]  state;
  logic [15:0] burst_left;
  logic [31:0] ce_count;

  clock_step_controller #(
    .CNT_W(16), .DEFAULT_DIV(2), .CE_CNT_W(32)
  ) dut (
    .CLK(CLK), .RESET(RESET), .halt_req(halt_req),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .core_ce(core_ce),
    .state(state), .burst_left(burst_left), .ce_count(ce_count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        ce;
    logic [1:0]  st;
    logic [15:0] bl;
    logic        rdy;
  } exp_t;

  exp_t        q[$];
  int          ncmp = 0;
  int          nfail = 0;
  logic [31:0] exp_cnt = 0;

  localparam logic [1:0] OP_HALT = 2'b00, OP_RUN = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10, OP_BURST = 2'b11;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic ce, input logic [1:0] st,
                      input logic [15:0] bl, input logic rdy);
    exp_t e;
    e.ce = ce; e.st = st; e.bl = bl; e.rdy = rdy;
    q.push_back(e);
  endtask

  task automatic cyc(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      chk("q_nonempty", (q.size() > 0) ? 1 : 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        exp_cnt += {31'd0, e.ce};
        chk("core_ce", {31'd0, core_ce}, {31'd0, e.ce});
        chk("state", {30'd0, state}, {30'd0, e.st});
        chk("burst_left", {16'd0, burst_left}, {16'd0, e.bl});
        chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, e.rdy});
        chk("ce_count", ce_count, exp_cnt);
      end
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] arg);
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_valid = 1'b1;
    #0;
    chk("ready_before_cmd", {31'd0, cmd_ready}, 1);
    cyc(1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; halt_req = 1'b0; cmd_valid = 1'b0;
    cmd_op = 2'b00; cmd_arg = '0;
    #12;
    chk("rst_ce", {31'd0, core_ce}, 0);
    chk("rst_state", {30'd0, state}, 0);
    chk("rst_bl", {16'd0, burst_left}, 0);
    chk("rst_cnt", ce_count, 0);
    chk("rst_ready", {31'd0, cmd_ready}, 1);
    RESET = 1'b0;

    // RUN div=3: pulses after E0+3, +6, +9
    push(0, 1, 0, 1);
    for (int k = 1; k <= 9; k++) push((k % 3) == 0, 1, 0, 1);
    send(OP_RUN, 16'd3);
    cyc(9);

    // RUN arg=0 -> div 1, continuous; HALT at E0+5
    push(0, 1, 0, 1);
    for (int k = 1; k <= 4; k++) push(1, 1, 0, 1);
    send(OP_RUN, 16'd0);
    cyc(4);
    push(0, 0, 0, 1);
    send(OP_HALT, 16'd0);
    push(0, 0, 0, 1); push(0, 0, 0, 1);
    cyc(2);

    // Two back-to-back STEPs
    push(0, 2, 0, 0); push(1, 0, 0, 1);
    send(OP_STEP, 16'd0);
    cyc(1);
    push(0, 2, 0, 0); push(1, 0, 0, 1); push(0, 0, 0, 1);
    send(OP_STEP, 16'd0);
    cyc(2);

    // RUN div=2, BURST 4 at E0r+2 suppresses the due pulse
    push(0, 1, 0, 1); push(0, 1, 0, 1);
    send(OP_RUN, 16'd2);
    cyc(1);
    push(0, 3, 4, 0);
    for (int k = 1; k <= 8; k++)
      push((k % 2) == 0, (k < 8) ? 2'd3 : 2'd0,
           16'(4 - k / 2), k == 8);
    send(OP_BURST, 16'd4);
    cyc(8);

    // BURST 0: consumed, nothing happens
    push(0, 0, 0, 1);
    send(OP_BURST, 16'd0);
    push(0, 0, 0, 1); push(0, 0, 0, 1);
    cyc(2);

    // halt_req during BURST with bl=2 and a due pulse
    push(0, 3, 4, 0); push(0, 3, 4, 0);
    push(1, 3, 3, 0); push(0, 3, 3, 0);
    push(1, 3, 2, 0); push(0, 3, 2, 0);
    send(OP_BURST, 16'd4);
    cyc(5);
    halt_req = 1'b1; cmd_valid = 1'b1;
    cmd_op = OP_RUN; cmd_arg = 16'd5;
    #0;
    chk("ready_halt", {31'd0, cmd_ready}, 0);
    push(0, 0, 0, 0);
    cyc(1);
    halt_req = 1'b0; cmd_valid = 1'b0;
    push(0, 0, 0, 1); push(0, 0, 0, 1);
    cyc(2);

    // Async RESET mid-RUN
    push(0, 1, 0, 1); push(1, 1, 0, 1); push(1, 1, 0, 1);
    send(OP_RUN, 16'd1);
    cyc(2);
    #2 RESET = 1'b1;
    #1;
    chk("mid_rst_ce", {31'd0, core_ce}, 0);
    chk("mid_rst_state", {30'd0, state}, 0);
    chk("mid_rst_bl", {16'd0, burst_left}, 0);
    chk("mid_rst_cnt", ce_count, 0);
    exp_cnt = 0;
    RESET = 1'b0;

    // BURST 3 right after reset uses DEFAULT_DIV=2
    push(0, 3, 3, 0);
    for (int k = 1; k <= 6; k++)
      push((k % 2) == 0, (k < 6) ? 2'd3 : 2'd0,
           16'(3 - k / 2), k == 6);
    send(OP_BURST, 16'd3);
    cyc(6);
    chk("q_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
